// File: rtl/parity_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : parity_arb_pkg
// Brief    : Shared FSM state encoding and requester indices for parity_arb.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package parity_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/parity_acc.sv
//------------------------------------------------------------------------------
// Module   : parity_acc
// Brief    : Running XOR-reduction accumulator with a saturating word counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module parity_acc #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_parity,
    output logic [CNT_W-1:0]  o_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= 1'b0;
            r_cnt <= '0;
        end else if (i_enable) begin
            r_acc <= r_acc ^ (^i_data);
            // Count sticks at all-ones so long frames never report a small count
            if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign o_parity = r_acc;
    assign o_count  = r_cnt;

endmodule

`default_nettype wire

// File: rtl/parity_arb.sv
//------------------------------------------------------------------------------
// Module   : parity_arb
// Brief    : Two-requester round-robin frame arbiter producing frame parity.
//            Optional res_xnor output enabled by macro PARITY_ARB_XNOR_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module parity_arb
    import parity_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              res_valid,
    output logic              res_parity,
    output logic              res_src,
    output logic [CNT_W-1:0]  res_count,
    input  logic              res_ready
`ifdef PARITY_ARB_XNOR_EN
    ,
    output logic              res_xnor
`endif
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_grant;
    logic                w_grant_next;
    logic                r_prio;
    logic                w_xfer;
    logic                w_last;
    logic                w_res_xfer;
    logic [DATA_W-1:0]   w_data;

    assign req0_ready = (r_state == BUSY) && (r_grant == REQ0);
    assign req1_ready = (r_state == BUSY) && (r_grant == REQ1);
    assign res_valid  = (r_state == RESULT);

    assign w_xfer     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_data     = (r_grant == REQ1) ? req1_data : req0_data;
    assign w_last     = (r_grant == REQ1) ? req1_last : req0_last;
    assign w_res_xfer = res_valid && res_ready;

    always_comb begin
        w_next_state = r_state;
        w_grant_next = r_grant;
        case (r_state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    w_next_state = BUSY;
                    if (req0_valid && req1_valid) begin
                        w_grant_next = r_prio;
                    end else begin
                        w_grant_next = req1_valid ? REQ1 : REQ0;
                    end
                end
            end
            BUSY: begin
                if (w_xfer && w_last) begin
                    w_next_state = RESULT;
                end
            end
            RESULT: begin
                if (w_res_xfer) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= REQ0;
            r_prio  <= REQ0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_grant_next;
            // The requester just served loses priority on the next tie
            if (w_res_xfer) begin
                r_prio <= ~r_grant;
            end
        end
    end

    parity_acc #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_res_xfer),
        .i_enable (w_xfer),
        .i_data   (w_data),
        .o_parity (res_parity),
        .o_count  (res_count)
    );

    assign res_src = r_grant;

`ifdef PARITY_ARB_XNOR_EN
    assign res_xnor = ~res_parity;
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_parity_arb
// Brief    : Directed self-checking bench for parity_arb.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_parity_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       res_valid, res_parity, res_src, res_ready;
    logic [7:0] res_count;
`ifdef PARITY_ARB_XNOR_EN
    logic       res_xnor;
`endif

    int n_checks = 0;
    int n_errors = 0;

    parity_arb #(
        .DATA_W (8),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_parity (res_parity),
        .res_src    (res_src),
        .res_count  (res_count),
        .res_ready  (res_ready)
`ifdef PARITY_ARB_XNOR_EN
        ,
        .res_xnor   (res_xnor)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input logic src);
        return src ? req1_ready : req0_ready;
    endfunction

    task automatic accept(input logic src);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (rdy(src)) done = 1'b1;
            step();
        end
        if (src) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
        check("accept_done", done, 1);
    endtask

    task automatic push(input logic src, input logic [7:0] d, input logic last);
        if (src) begin
            req1_valid = 1'b1; req1_data = d; req1_last = last;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_last = last;
        end
        accept(src);
    endtask

    task automatic wait_result(input logic exp_par, input logic exp_src, input logic [7:0] exp_cnt);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (res_valid) seen = 1'b1;
            else           step();
        end
        check("res_seen", seen, 1);
        check("res_parity", res_parity, exp_par);
        check("res_src", res_src, exp_src);
        check("res_count", res_count, exp_cnt);
`ifdef PARITY_ARB_XNOR_EN
        check("res_xnor", res_xnor, ~exp_par);
`endif
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    // Both requesters offer a one-word frame together; 'first' must win.
    task automatic dual(input logic [7:0] d, input logic first, input logic exp_par, input int stall);
        req0_valid = 1'b1; req0_data = d; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = d; req1_last = 1'b1;
        accept(first);
        for (int i = 0; i < stall; i++) begin
            check("stall_outputs",
                  {req0_ready, req1_ready, res_valid, res_parity, res_src, res_count},
                  {1'b0, 1'b0, 1'b1, exp_par, first, 8'd1});
            step();
        end
        wait_result(exp_par, first, 8'd1);
        check("turn_idle", rdy(~first), 0);
        step();
        check("turn_busy", rdy(~first), 1);
        accept(~first);
        wait_result(exp_par, ~first, 8'd1);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
        res_ready  = 1'b0;
        step();
        step();
        check("rst_outputs",
              {req0_ready, req1_ready, res_valid, res_parity, res_src, res_count}, 0);
        rst = 1'b0;
        step();

        // Tie right after reset: requester 0 first, result held under backpressure
        dual(8'h48, 1'b0, 1'b0, 5);

        // Three-word frame on req0 with gaps; req1 pending must be ignored
        push(1'b0, 8'h48, 1'b0);
        req1_valid = 1'b1; req1_data = 8'h31; req1_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("nongrant_ready", req1_ready, 0);
            check("hold_grant", req0_ready, 1);
            step();
        end
        push(1'b0, 8'h69, 1'b0);
        push(1'b0, 8'h31, 1'b1);
        wait_result(1'b1, 1'b0, 8'd3);
        accept(1'b1);
        wait_result(1'b1, 1'b1, 8'd1);

        // req0 served last, so the next tie goes to req1
        push(1'b0, 8'h31, 1'b1);
        wait_result(1'b1, 1'b0, 8'd1);
        dual(8'h69, 1'b1, 1'b0, 0);

        // Reset mid-frame discards the partial frame
        push(1'b0, 8'h48, 1'b0);
        push(1'b0, 8'h69, 1'b0);
        rst = 1'b1;
        step();
        check("rst_mid",
              {req0_ready, req1_ready, res_valid, res_parity, res_src, res_count}, 0);
        rst = 1'b0;
        push(1'b0, 8'h31, 1'b1);
        wait_result(1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 3; i++) begin
            check("no_extra_result", res_valid, 0);
            step();
        end

        // 256-word frame saturates the counter
        for (int i = 0; i < 256; i++) begin
            push(1'b0, 8'h01, (i == 255));
        end
        wait_result(1'b0, 1'b0, 8'd255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
